// File: rtl/program_loader.sv
// Instruction-memory program loader: assembles a little-endian byte stream into 32-bit words and writes them.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd4,
    parameter logic [31:0] MAX_WORDS = 32'd23001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] pro_addr,
    output logic [31:0] pro_data,
    output logic        memwrite,
    output logic        loading,
    output logic        done,
    output logic        err,
    output logic [31:0] word_cnt
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_CSUM, ST_DONE, ST_ERR} state_t;
`else
    typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_DONE, ST_ERR} state_t;
`endif

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] hdr;
    logic [31:0] word_buf;
    logic [31:0] hdr_next;
    logic [31:0] word_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // The final byte of a header/word completes the value in the same cycle it arrives.
    assign hdr_next  = {rx_data, hdr[23:0]};
    assign word_next = {rx_data, word_buf[23:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HDR;
            byte_idx <= 2'd0;
            hdr      <= 32'd0;
            word_buf <= 32'd0;
            pro_addr <= 32'd0;
            pro_data <= 32'd0;
            memwrite <= 1'b0;
            loading  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
        end else begin
            memwrite <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (rx_valid) begin
                        loading <= 1'b1;
                        hdr[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (hdr_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state   <= ST_CSUM;
`else
                                state   <= ST_DONE;
                                done    <= 1'b1;
                                loading <= 1'b0;
`endif
                            end else if (hdr_next > MAX_WORDS) begin
                                state   <= ST_ERR;
                                err     <= 1'b1;
                                loading <= 1'b0;
                            end else begin
                                state   <= ST_DATA;
                            end
                        end
                    end
                end
                // Write is issued from the registered outputs; DONE raises done one cycle later.
                ST_DATA: begin
                    if (rx_valid) begin
                        word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (byte_idx == 2'd3) begin
                            memwrite <= 1'b1;
                            pro_addr <= BASE_ADDR + (word_cnt << 2);
                            pro_data <= word_next;
                            word_cnt <= word_cnt + 32'd1;
                            if (word_cnt + 32'd1 == hdr) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= ST_CSUM;
`else
                                state <= ST_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        loading <= 1'b0;
                        if (rx_data == csum) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    done    <= 1'b1;
                    loading <= 1'b0;
                end
                ST_ERR: begin
                    err     <= 1'b1;
                    loading <= 1'b0;
                end
                default: begin
                    state <= ST_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of images plus hand sequences, writes checked via a scoreboard.
// Exercises the checksum path when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    localparam logic [31:0] MAX_WORDS = 32'd23001;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] pro_addr;
    logic [31:0] pro_data;
    logic        memwrite;
    logic        loading;
    logic        done;
    logic        err;
    logic [31:0] word_cnt;

    program_loader dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .pro_addr (pro_addr),
        .pro_data (pro_data),
        .memwrite (memwrite),
        .loading  (loading),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cnt;
    } wr_t;

    typedef struct {
        string           name;
        logic [31:0]     hdr;
        logic [2:0][31:0] words;
        int              gap;
        int              extra;
        logic            exp_done;
        logic            exp_err;
        logic [31:0]     exp_cnt;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_e;
    vec_t vecs[5];
    vec_t hv;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (memwrite === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write", pro_addr, pro_data);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("wr_addr", pro_addr, mon_e.addr);
                checkOutput("wr_data", pro_data, mon_e.data);
                checkOutput("wr_cnt", word_cnt, mon_e.cnt);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int g);
        if (g == 0) return 0;
        return int'($urandom_range(g, 0));
    endfunction

    task automatic doReset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_memwrite", {31'd0, memwrite}, 32'd0);
        checkOutput("rst_loading", {31'd0, loading}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_word_cnt", word_cnt, 32'd0);
        checkOutput("rst_pro_addr", pro_addr, 32'd0);
        rst = 1'b0;
    endtask

    task automatic sendImage(input vec_t v);
        logic [7:0] x;
        int nw;
        x = 8'd0;
        for (int k = 0; k < 4; k++) applyStimulus(v.hdr[8*k +: 8], pick_gap(v.gap));
        if (v.hdr <= MAX_WORDS) begin
            nw = int'(v.hdr);
            for (int i = 0; i < nw; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (b == 3) sb.push_back({32'd4 + 32'(4 * i), v.words[i], 32'(i + 1)});
                    x = x ^ v.words[i][8*b +: 8];
                    applyStimulus(v.words[i][8*b +: 8], pick_gap(v.gap));
                end
            end
`ifdef LOADER_CHECKSUM_EN
            applyStimulus(x, pick_gap(v.gap));
`endif
        end
        for (int e = 0; e < v.extra; e++) applyStimulus(8'($urandom), 0);
    endtask

    task automatic runImage(input vec_t v);
        sendImage(v);
        repeat (3) @(negedge clk);
        checkOutput({v.name, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
        checkOutput({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
        checkOutput({v.name, "_loading"}, {31'd0, loading}, 32'd0);
        checkOutput({v.name, "_word_cnt"}, word_cnt, v.exp_cnt);
        checkOutput({v.name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;

        vecs[0] = '{"basic", 32'd2, {32'd0, 32'h00100093, 32'h00000013}, 0, 0, 1'b1, 1'b0, 32'd2};
        vecs[1] = '{"zero", 32'd0, {32'd0, 32'd0, 32'd0}, 0, 0, 1'b1, 1'b0, 32'd0};
        vecs[2] = '{"oversize", 32'd23002, {32'd0, 32'd0, 32'd0}, 0, 16, 1'b0, 1'b1, 32'd0};
        vecs[3] = '{"gapped", 32'd3, {32'hFFEE0055, 32'h01020304, 32'hA1B2C3D4}, 7, 0, 1'b1, 1'b0, 32'd3};
        vecs[4] = '{"b2b", 32'd3, {32'hFFEE0055, 32'h01020304, 32'hA1B2C3D4}, 0, 0, 1'b1, 1'b0, 32'd3};

        for (int t = 0; t < 5; t++) begin
            doReset();
            runImage(vecs[t]);
        end

        // Exact write and done latency after the final byte.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus((k == 0) ? 8'h01 : 8'h00, 0);
        checkOutput("lat_loading", {31'd0, loading}, 32'd1);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        sb.push_back({32'd4, 32'h44332211, 32'd1});
        applyStimulus(8'h44, 0);
        checkOutput("lat_memwrite", {31'd0, memwrite}, 32'd1);
        checkOutput("lat_done_early", {31'd0, done}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(8'h44, 0);
        checkOutput("csum_ok_done", {31'd0, done}, 32'd1);
        checkOutput("csum_ok_err", {31'd0, err}, 32'd0);
`else
        @(negedge clk);
        checkOutput("lat_done", {31'd0, done}, 32'd1);
        checkOutput("lat_memwrite_low", {31'd0, memwrite}, 32'd0);
`endif
        checkOutput("lat_sb_empty", 32'(sb.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: the word is still written but the image is rejected.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus((k == 0) ? 8'h01 : 8'h00, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        sb.push_back({32'd4, 32'h44332211, 32'd1});
        applyStimulus(8'h44, 0);
        applyStimulus(8'h45, 0);
        checkOutput("csum_bad_err", {31'd0, err}, 32'd1);
        checkOutput("csum_bad_done", {31'd0, done}, 32'd0);
        checkOutput("csum_bad_sb_empty", 32'(sb.size()), 32'd0);
`endif

        // Header exactly at MAX_WORDS is accepted and loading proceeds.
        doReset();
        applyStimulus(8'hD9, 0);
        applyStimulus(8'h59, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        sb.push_back({32'd4, 32'hCAFEF00D, 32'd1});
        for (int b = 0; b < 4; b++) begin
            hv.hdr = 32'hCAFEF00D;
            applyStimulus(hv.hdr[8*b +: 8], 0);
        end
        repeat (2) @(negedge clk);
        checkOutput("max_err", {31'd0, err}, 32'd0);
        checkOutput("max_done", {31'd0, done}, 32'd0);
        checkOutput("max_loading", {31'd0, loading}, 32'd1);
        checkOutput("max_word_cnt", word_cnt, 32'd1);
        checkOutput("max_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-load abandons the partial image; a fresh image loads cleanly.
        doReset();
        applyStimulus(8'h04, 0);
        for (int k = 0; k < 3; k++) applyStimulus(8'h00, 0);
        sb.push_back({32'd4, 32'h87654321, 32'd1});
        applyStimulus(8'h21, 1);
        applyStimulus(8'h43, 0);
        applyStimulus(8'h65, 2);
        applyStimulus(8'h87, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        @(negedge clk);
        checkOutput("mid_loading", {31'd0, loading}, 32'd1);
        checkOutput("mid_word_cnt", word_cnt, 32'd1);
        doReset();
        hv = '{"fresh", 32'd1, {32'd0, 32'd0, 32'hDEADBEEF}, 3, 0, 1'b1, 1'b0, 32'd1};
        runImage(hv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
